// File: rtl/trap_csr_seq.sv
// Trap entry / mret sequencer that owns the CSR write port while a trap or return is in flight.
// Optional feature macro: TRAP_MTVAL_EN adds the mtval write state.
module trap_csr_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap_req,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_tval,
  input  logic        mret_req,
  output logic        trap_ack,
  output logic        busy,
  input  logic [11:0] pipe_csr_addr_r,
  output logic [31:0] pipe_csr_data_r,
  input  logic        pipe_csr_we,
  input  logic [11:0] pipe_csr_addr_w,
  input  logic [31:0] pipe_csr_data_w,
  output logic [11:0] csr_addr_r,
  input  logic [31:0] csr_data_r,
  output logic        csr_we,
  output logic [11:0] csr_addr_w,
  output logic [31:0] csr_data_w,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 12;

  localparam logic [AW-1:0] CSR_MSTATUS = AW'(12'h300);
  localparam logic [AW-1:0] CSR_MTVEC   = AW'(12'h305);
  localparam logic [AW-1:0] CSR_MEPC    = AW'(12'h341);
  localparam logic [AW-1:0] CSR_MCAUSE  = AW'(12'h342);
`ifdef TRAP_MTVAL_EN
  localparam logic [AW-1:0] CSR_MTVAL   = AW'(12'h343);
`endif

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_EPC    = 3'd1,
    W_CAUSE  = 3'd2,
`ifdef TRAP_MTVAL_EN
    W_TVAL   = 3'd3,
`endif
    W_STATUS = 3'd4,
    M_STATUS = 3'd5,
    REDIRECT = 3'd6
  } state_t;

  state_t          state;
  logic            is_mret;
  logic [XLEN-1:0] cause_q;
  logic [XLEN-1:0] pc_q;
`ifdef TRAP_MTVAL_EN
  logic [XLEN-1:0] tval_q;
`else
  logic            unused_tval;
  assign unused_tval = ^trap_tval;
`endif

  // Sequencer state, latched trap operands, and the registered busy/redirect flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      is_mret        <= 1'b0;
      cause_q        <= '0;
      pc_q           <= '0;
`ifdef TRAP_MTVAL_EN
      tval_q         <= '0;
`endif
      busy           <= 1'b0;
      redirect_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (trap_req) begin
            state   <= W_EPC;
            is_mret <= 1'b0;
            cause_q <= trap_cause;
            pc_q    <= trap_pc;
`ifdef TRAP_MTVAL_EN
            tval_q  <= trap_tval;
`endif
            busy    <= 1'b1;
          end else if (mret_req) begin
            state   <= M_STATUS;
            is_mret <= 1'b1;
            busy    <= 1'b1;
          end
        end
        W_EPC: state <= W_CAUSE;
`ifdef TRAP_MTVAL_EN
        W_CAUSE: state <= W_TVAL;
        W_TVAL:  state <= W_STATUS;
`else
        W_CAUSE: state <= W_STATUS;
`endif
        W_STATUS, M_STATUS: begin
          state          <= REDIRECT;
          redirect_valid <= 1'b1;
        end
        REDIRECT: begin
          state          <= IDLE;
          busy           <= 1'b0;
          redirect_valid <= 1'b0;
        end
        default: begin
          state          <= IDLE;
          busy           <= 1'b0;
          redirect_valid <= 1'b0;
        end
      endcase
    end
  end

  assign trap_ack        = (state == IDLE) && !rst && (trap_req || mret_req);
  assign pipe_csr_data_r = csr_data_r;

  // Trap target: base plus 4*cause for vectored mode on interrupts
  logic [XLEN-1:0] mtvec_base;
  logic [XLEN-1:0] vec_off;
  logic [XLEN-1:0] trap_target;
  assign mtvec_base  = {csr_data_r[XLEN-1:2], 2'b00};
  assign vec_off     = ((csr_data_r[1:0] == 2'b01) && cause_q[XLEN-1])
                       ? {cause_q[XLEN-3:0], 2'b00} : '0;
  assign trap_target = mtvec_base + vec_off;

  logic [XLEN-1:0] status_trap;
  logic [XLEN-1:0] status_mret;
  always_comb begin
    status_trap        = csr_data_r;
    status_trap[7]     = csr_data_r[3];
    status_trap[3]     = 1'b0;
    status_trap[12:11] = 2'b11;
    status_mret        = csr_data_r;
    status_mret[3]     = csr_data_r[7];
    status_mret[7]     = 1'b1;
    status_mret[12:11] = 2'b11;
  end

  // CSR port steering: pipeline pass-through in IDLE, sequencer-owned otherwise
  always_comb begin
    csr_addr_r  = '0;
    csr_we      = 1'b0;
    csr_addr_w  = '0;
    csr_data_w  = '0;
    redirect_pc = '0;
    case (state)
      IDLE: begin
        csr_addr_r = pipe_csr_addr_r;
        csr_we     = pipe_csr_we;
        csr_addr_w = pipe_csr_addr_w;
        csr_data_w = pipe_csr_data_w;
      end
      W_EPC: begin
        csr_we     = !rst;
        csr_addr_w = CSR_MEPC;
        csr_data_w = pc_q;
      end
      W_CAUSE: begin
        csr_we     = !rst;
        csr_addr_w = CSR_MCAUSE;
        csr_data_w = cause_q;
      end
`ifdef TRAP_MTVAL_EN
      W_TVAL: begin
        csr_we     = !rst;
        csr_addr_w = CSR_MTVAL;
        csr_data_w = tval_q;
      end
`endif
      W_STATUS: begin
        csr_addr_r = CSR_MSTATUS;
        csr_we     = !rst;
        csr_addr_w = CSR_MSTATUS;
        csr_data_w = status_trap;
      end
      M_STATUS: begin
        csr_addr_r = CSR_MSTATUS;
        csr_we     = !rst;
        csr_addr_w = CSR_MSTATUS;
        csr_data_w = status_mret;
      end
      REDIRECT: begin
        csr_addr_r  = is_mret ? CSR_MEPC : CSR_MTVEC;
        redirect_pc = is_mret ? {csr_data_r[XLEN-1:2], 2'b00} : trap_target;
      end
      default: begin
        csr_addr_r = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_trap_csr_seq.sv
// Self-checking bench for trap_csr_seq: CSR file environment, event monitor and a behavioural reference.
module tb_trap_csr_seq;

`ifdef TRAP_MTVAL_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif

  typedef struct packed {
    int          cyc;
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct packed {
    int          cyc;
    logic [31:0] pc;
  } rd_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        trap_req, mret_req;
  logic [31:0] trap_cause, trap_pc, trap_tval;
  logic        trap_ack, busy;
  logic [11:0] pipe_csr_addr_r;
  logic [31:0] pipe_csr_data_r;
  logic        pipe_csr_we;
  logic [11:0] pipe_csr_addr_w;
  logic [31:0] pipe_csr_data_w;
  logic [11:0] csr_addr_r;
  logic [31:0] csr_data_r;
  logic        csr_we;
  logic [11:0] csr_addr_w;
  logic [31:0] csr_data_w;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  trap_csr_seq dut (
    .clk(clk), .rst(rst),
    .trap_req(trap_req), .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_tval(trap_tval),
    .mret_req(mret_req), .trap_ack(trap_ack), .busy(busy),
    .pipe_csr_addr_r(pipe_csr_addr_r), .pipe_csr_data_r(pipe_csr_data_r),
    .pipe_csr_we(pipe_csr_we), .pipe_csr_addr_w(pipe_csr_addr_w), .pipe_csr_data_w(pipe_csr_data_w),
    .csr_addr_r(csr_addr_r), .csr_data_r(csr_data_r),
    .csr_we(csr_we), .csr_addr_w(csr_addr_w), .csr_data_w(csr_data_w),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // CSR file environment with combinational read and a preload port for the bench
  logic [31:0] csr_mem [0:4095];
  logic        pl_we = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [31:0] pl_data = '0;
  assign csr_data_r = csr_mem[csr_addr_r];
  always @(posedge clk) begin
    if (csr_we) csr_mem[csr_addr_w] <= csr_data_w;
    if (pl_we)  csr_mem[pl_addr]    <= pl_data;
  end

  wr_t wq[$];
  rd_t rq[$];
  int  aq[$];
  always @(negedge clk) begin
    if (trap_ack)       aq.push_back(cyc);
    if (csr_we)         wq.push_back(wr_t'{cyc: cyc, addr: csr_addr_w, data: csr_data_w});
    if (redirect_valid) rq.push_back(rd_t'{cyc: cyc, pc: redirect_pc});
  end

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [31:0] ref_trap_status(input logic [31:0] old);
    logic [31:0] r;
    r = (old & ~32'h0000_1888) | 32'h0000_1800;
    if (old[3]) r = r | 32'h0000_0080;
    return r;
  endfunction

  function automatic logic [31:0] ref_mret_status(input logic [31:0] old);
    logic [31:0] r;
    r = (old & ~32'h0000_1888) | 32'h0000_1880;
    if (old[7]) r = r | 32'h0000_0008;
    return r;
  endfunction

  function automatic logic [31:0] ref_target(input logic [31:0] mtvec, input logic [31:0] cause);
    logic [31:0] t;
    t = mtvec & ~32'h3;
    if ((mtvec % 4) == 1 && cause[31]) t = t + (cause << 2);
    return t;
  endfunction

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; trap_req = 1'b0; mret_req = 1'b0; pipe_csr_we = 1'b0;
    trap_cause = '0; trap_pc = '0; trap_tval = '0;
    pipe_csr_addr_r = '0; pipe_csr_addr_w = '0; pipe_csr_data_w = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b exp 0", busy); end
    n_cmp++; if (trap_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b exp 0", trap_ack); end
    n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL reset_rv: got %b exp 0", redirect_valid); end
    n_cmp++; if (redirect_pc !== 32'h0) begin n_err++; $display("FAIL reset_rpc: got %h exp 0", redirect_pc); end
    n_cmp++; if (csr_we !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b exp 0", csr_we); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_passthrough();
    for (int i = 0; i < 6; i++) begin
      logic [11:0] ra;
      logic [31:0] rv;
      ra = 12'(12'h7C0 + 12'(i));
      rv = $urandom;
      preload(ra, rv);
      pipe_csr_addr_r = ra;
      pipe_csr_we     = 1'($urandom_range(0, 1));
      pipe_csr_addr_w = 12'(12'h7D0 + 12'(i));
      pipe_csr_data_w = $urandom;
      @(negedge clk);
      n_cmp++; if (csr_addr_r !== ra) begin n_err++; $display("FAIL pt_addr_r: got %h exp %h", csr_addr_r, ra); end
      n_cmp++; if (pipe_csr_data_r !== rv) begin n_err++; $display("FAIL pt_data_r: got %h exp %h", pipe_csr_data_r, rv); end
      n_cmp++; if ({csr_we, csr_addr_w, csr_data_w} !== {pipe_csr_we, pipe_csr_addr_w, pipe_csr_data_w}) begin
        n_err++; $display("FAIL pt_write: got %b/%h/%h exp %b/%h/%h", csr_we, csr_addr_w, csr_data_w,
                          pipe_csr_we, pipe_csr_addr_w, pipe_csr_data_w);
      end
      @(posedge clk); #1;
      pipe_csr_we = 1'b0;
    end
  endtask

  task automatic run_trap(input logic [31:0] cause, input logic [31:0] pc, input logic [31:0] tval,
                          input logic [31:0] mtvec, input logic [31:0] status,
                          input bit with_mret, input bit pipe_pulse);
    wr_t exp_w[4];
    int  n_exp, wb, rb, ab, t0;
    preload(12'h305, mtvec);
    preload(12'h300, status);
    n_exp = 0;
    exp_w[n_exp++] = wr_t'{cyc: 0, addr: 12'h341, data: pc};
    exp_w[n_exp++] = wr_t'{cyc: 0, addr: 12'h342, data: cause};
`ifdef TRAP_MTVAL_EN
    exp_w[n_exp++] = wr_t'{cyc: 0, addr: 12'h343, data: tval};
`endif
    exp_w[n_exp++] = wr_t'{cyc: 0, addr: 12'h300, data: ref_trap_status(status)};
    wb = wq.size(); rb = rq.size(); ab = aq.size();
    trap_req = 1'b1; mret_req = with_mret;
    trap_cause = cause; trap_pc = pc; trap_tval = tval;
    t0 = cyc;
    for (int i = 0; i < n_exp; i++) exp_w[i].cyc = t0 + 1 + i;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL trap_busy_k0: got %b exp 0", busy); end
    for (int k = 1; k <= LAT + 2; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin trap_cause = $urandom; trap_pc = $urandom; trap_tval = $urandom; end
      if (k == 2) begin
        trap_req = 1'b0; mret_req = 1'b0;
        if (pipe_pulse) begin pipe_csr_we = 1'b1; pipe_csr_addr_w = 12'h7C0; pipe_csr_data_w = $urandom; end
      end
      if (k == 3) pipe_csr_we = 1'b0;
      @(negedge clk);
      n_cmp++; if (busy !== (k <= LAT)) begin n_err++; $display("FAIL trap_busy_k%0d: got %b exp %b", k, busy, (k <= LAT)); end
      if (k == LAT) begin
        n_cmp++; if (csr_we !== 1'b0) begin n_err++; $display("FAIL trap_redirect_we: got %b exp 0", csr_we); end
      end else begin
        n_cmp++; if (redirect_pc !== 32'h0) begin n_err++; $display("FAIL trap_rpc_idle_k%0d: got %h exp 0", k, redirect_pc); end
      end
    end
    n_cmp++; if (wq.size() - wb !== n_exp) begin n_err++; $display("FAIL trap_write_count: got %0d exp %0d", wq.size() - wb, n_exp); end
    for (int i = 0; i < n_exp && wb + i < wq.size(); i++) begin
      n_cmp++; if (wq[wb + i] !== exp_w[i]) begin
        n_err++; $display("FAIL trap_write%0d: got c%0d %h=%h exp c%0d %h=%h", i, wq[wb + i].cyc, wq[wb + i].addr,
                          wq[wb + i].data, exp_w[i].cyc, exp_w[i].addr, exp_w[i].data);
      end
    end
    n_cmp++; if (rq.size() - rb !== 1) begin n_err++; $display("FAIL trap_redirect_count: got %0d exp 1", rq.size() - rb); end
    else begin
      n_cmp++; if (rq[rb] !== rd_t'{cyc: t0 + LAT, pc: ref_target(mtvec, cause)}) begin
        n_err++; $display("FAIL trap_redirect: got c%0d %h exp c%0d %h", rq[rb].cyc, rq[rb].pc, t0 + LAT, ref_target(mtvec, cause));
      end
    end
    n_cmp++; if (aq.size() - ab !== 1 || aq[ab] !== t0) begin
      n_err++; $display("FAIL trap_ack: got %0d acks exp 1 at c%0d", aq.size() - ab, t0);
    end
  endtask

  task automatic run_mret(input logic [31:0] mepc, input logic [31:0] status);
    int wb, rb, ab, t0;
    preload(12'h341, mepc);
    preload(12'h300, status);
    wb = wq.size(); rb = rq.size(); ab = aq.size();
    mret_req = 1'b1;
    t0 = cyc;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k == 2) mret_req = 1'b0;
      @(negedge clk);
      n_cmp++; if (busy !== (k <= 2)) begin n_err++; $display("FAIL mret_busy_k%0d: got %b exp %b", k, busy, (k <= 2)); end
    end
    n_cmp++; if (wq.size() - wb !== 1) begin n_err++; $display("FAIL mret_write_count: got %0d exp 1", wq.size() - wb); end
    else begin
      n_cmp++; if (wq[wb] !== wr_t'{cyc: t0 + 1, addr: 12'h300, data: ref_mret_status(status)}) begin
        n_err++; $display("FAIL mret_status: got c%0d %h=%h exp c%0d 300=%h", wq[wb].cyc, wq[wb].addr, wq[wb].data,
                          t0 + 1, ref_mret_status(status));
      end
    end
    n_cmp++; if (rq.size() - rb !== 1) begin n_err++; $display("FAIL mret_redirect_count: got %0d exp 1", rq.size() - rb); end
    else begin
      n_cmp++; if (rq[rb] !== rd_t'{cyc: t0 + 2, pc: mepc & ~32'h3}) begin
        n_err++; $display("FAIL mret_redirect: got c%0d %h exp c%0d %h", rq[rb].cyc, rq[rb].pc, t0 + 2, mepc & ~32'h3);
      end
    end
    n_cmp++; if (aq.size() - ab !== 1 || aq[ab] !== t0) begin
      n_err++; $display("FAIL mret_ack: got %0d acks exp 1 at c%0d", aq.size() - ab, t0);
    end
  endtask

  task automatic test_reset_mid();
    int wb, rb, t0, bad;
    preload(12'h305, 32'h8000_0100);
    preload(12'h300, 32'h0000_0008);
    wb = wq.size(); rb = rq.size();
    trap_req = 1'b1; trap_cause = 32'h2; trap_pc = 32'h8000_0040; trap_tval = 32'hDEAD_BEEF;
    t0 = cyc;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 1) trap_req = 1'b0;
      if (k == 2) rst = 1'b1;
      if (k == 3) rst = 1'b0;
      @(negedge clk);
      if (k >= 3) begin
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy_k%0d: got %b exp 0", k, busy); end
      end
    end
    bad = 0;
    for (int i = wb; i < wq.size(); i++) if (wq[i].addr == 12'h343 || wq[i].addr == 12'h300) bad++;
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL rstmid_late_writes: got %0d exp 0", bad); end
    n_cmp++; if (rq.size() - rb !== 0) begin n_err++; $display("FAIL rstmid_redirect: got %0d exp 0", rq.size() - rb); end
    n_cmp++; if (wq.size() <= wb || wq[wb] !== wr_t'{cyc: t0 + 1, addr: 12'h341, data: 32'h8000_0040}) begin
      n_err++; $display("FAIL rstmid_mepc: got %0d writes exp mepc at c%0d", wq.size() - wb, t0 + 1);
    end
  endtask

  task automatic test_random_traps();
    for (int i = 0; i < 6; i++) begin
      logic [31:0] mtvec;
      mtvec = ($urandom & ~32'h3) | 32'($urandom_range(0, 1));
      run_trap($urandom, $urandom, $urandom, mtvec, $urandom, 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  task automatic test_random_mrets();
    for (int i = 0; i < 4; i++) run_mret($urandom, $urandom);
  endtask

  initial begin
    test_reset();
    test_passthrough();
    run_trap(32'h2, 32'h8000_0040, 32'hDEAD_BEEF, 32'h8000_0100, 32'h8, 1'b0, 1'b0);
    run_trap(32'h8000_0007, 32'h8000_0200, 32'h0, 32'h8000_0101, 32'h0, 1'b0, 1'b0);
    run_mret(32'h8000_0044, 32'h1880);
    run_trap(32'hB, 32'h1234_5678, 32'h55AA_55AA, 32'h0000_2000, 32'h88, 1'b1, 1'b1);
    test_reset_mid();
    test_random_traps();
    test_random_mrets();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/trap_csr_seq.md
TRAP_CSR_SEQ -- requirements
Module: trap_csr_seq

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk, rst.
REQ-002 Ports, as name  direction  width  meaning:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- trap_req  in  1  level request to take a trap.
- trap_cause  in  32  mcause value.
- trap_pc  in  32  faulting PC.
- trap_tval  in  32  mtval value.
- mret_req  in  1  level request to return from trap.
- trap_ack  out  1  one-cycle pulse; request accepted, operands latched.
- busy  out  1  sequencer active; pipeline stalls CSR access.
- pipe_csr_addr_r  in  12  pipeline CSR read address.
- pipe_csr_data_r  out  32  pipeline CSR read data.
- pipe_csr_we  in  1  pipeline CSR write enable.
- pipe_csr_addr_w  in  12  pipeline CSR write address.
- pipe_csr_data_w  in  32  pipeline CSR write data.
- csr_addr_r  out  12  to CSR file read address.
- csr_data_r  in  32  from CSR file, combinational read data.
- csr_we  out  1  to CSR file write enable.
- csr_addr_w  out  12  to CSR file write address.
- csr_data_w  out  32  to CSR file write data.
- redirect_valid  out  1  one-cycle pulse; fetch jumps to redirect_pc.
- redirect_pc  out  32  trap target or return PC.

Function
REQ-003 FSM states SHALL be IDLE, W_EPC, W_CAUSE, W_TVAL, W_STATUS, M_STATUS and REDIRECT; busy=1 in every state except IDLE.
REQ-004 In IDLE, pipeline ports SHALL pass through combinationally to the CSR file: csr_we=pipe_csr_we, addr/data likewise, csr_addr_r=pipe_csr_addr_r.
REQ-005 pipe_csr_data_r SHALL equal csr_data_r in all states.
REQ-006 In IDLE with trap_req=1: trap_ack=1, latch cause/pc/tval, next state W_EPC.
REQ-007 In IDLE with mret_req=1 and trap_req=0: trap_ack=1, next state M_STATUS.
REQ-008 trap_req SHALL win over a simultaneous mret_req.
REQ-009 trap_req/mret_req while busy SHALL be ignored, with no ack.
REQ-010 While busy, pipe_csr_we SHALL be ignored; only the sequencer drives the write port.
REQ-011 W_EPC SHALL write 0x341 <= latched pc, then go to W_CAUSE.
REQ-012 W_CAUSE SHALL write 0x342 <= latched cause, then go to W_TVAL (or W_STATUS, see REQ-020).
REQ-013 W_TVAL SHALL write 0x343 <= latched tval, then go to W_STATUS.
REQ-014 W_STATUS SHALL:
- read 0x300;
- write 0x300 with bit7 (MPIE) <= old bit3, bit3 (MIE) <= 0, bits12:11 (MPP) <= 2'b11, other bits unchanged;
- then go to REDIRECT.
REQ-015 M_STATUS SHALL:
- read 0x300;
- write 0x300 with bit3 <= old bit7, bit7 <= 1, bits12:11 <= 2'b11, others unchanged;
- then go to REDIRECT.
REQ-016 REDIRECT after a trap SHALL read 0x305 (mtvec) and assert redirect_valid for 1 cycle:
- redirect_pc = {mtvec[31:2],2'b00} + (mtvec[1:0]==2'b01 && cause[31] ? {cause[29:0],2'b00} : 0), 32-bit wrap.
REQ-017 REDIRECT after an mret SHALL read 0x341 and set redirect_pc = {mepc[31:2],2'b00}; it SHALL then return to IDLE.
REQ-018 Latency:
- Trap: accept at cycle T, writes at T+1..T+4, redirect_valid at T+5, IDLE at T+6.
- Mret: accept at T, status write at T+1, redirect at T+2.
- Exactly one CSR write per write state; csr_we=0 in REDIRECT.
REQ-019 Outside REDIRECT, redirect_valid=0 and redirect_pc=0. Outside write states, the sequencer SHALL drive csr_we=0, with csr_addr_w=0 and csr_data_w=0 when busy.

Configuration
REQ-020 Macro TRAP_MTVAL_EN:
- Defined: W_TVAL exists and writes mtval.
- Undefined: W_TVAL is removed, W_CAUSE goes directly to W_STATUS, trap_tval is ignored, and the trap redirect moves to T+4.

Reset
REQ-021 When rst=1 at a clock edge:
- state -> IDLE, latched operands -> 0;
- trap_ack, busy, redirect_valid, redirect_pc -> 0;
- the sequencer drives no CSR write.
REQ-022 Reset mid-sequence SHALL abandon the sequence with no further writes and no redirect.

Verification
REQ-023 Bench SHALL cover these scenarios (trap-sequence cases with TRAP_MTVAL_EN defined):
- Trap, mtvec=0x80000100, cause=0x2, pc=0x80000040, tval=0xDEADBEEF, mstatus=0x8 -> writes mepc, mcause, mtval, mstatus=0x1880; redirect 0x80000100 at T+5.
- Vectored: mtvec=0x80000101, cause=0x80000007 -> redirect_pc=0x8000011C.
- Mret, mepc=0x80000044, mstatus=0x1880 -> mstatus=0x1888 at T+1; redirect 0x80000044 at T+2.
- trap_req and mret_req in the same cycle -> trap sequence only; a pipe_csr_we pulse during busy produces no write.
- rst asserted at T+2 of a trap -> no mtval/mstatus write, no redirect_valid, busy=0 the next cycle.
- TRAP_MTVAL_EN undefined -> no 0x343 write; redirect at T+4.
